// File: rtl/axi_mem_master_pkg.sv
// Shared definitions for the single-outstanding AXI4 memory initiator.
// Contents: FSM state encoding, AXI response/burst/cache constants and a
// helper that derives the AXI beat size from the data-bus width.
package axi_mem_master_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        BWAIT = 3'd2,
        READ  = 3'd3,
        RWAIT = 3'd4,
        RESP  = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY        = 2'b00;
    localparam logic [1:0] BURST_INCR       = 2'b01;
    localparam logic [3:0] CACHE_MODIFIABLE = 4'b0010;

    // AXI size code: log2 of the number of bytes per beat (full-width beats only).
    function automatic logic [2:0] axi_size(input int unsigned data_width);
        return 3'($clog2(data_width / 32'd8));
    endfunction

endpackage

// File: rtl/axi_bus.sv
// AXI4 bus bundle connecting one initiator to one target.
// Parameters: address, data, ID and user widths.
// Modport out: the initiator view (drives AW/W/AR and B/R ready, samples the rest).
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 5,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        aw_lock;
    logic [3:0]                  aw_cache;
    logic [2:0]                  aw_prot;
    logic [3:0]                  aw_qos;
    logic [3:0]                  aw_region;
    logic [5:0]                  aw_atop;
    logic [AXI_USER_WIDTH-1:0]   aw_user;
    logic                        aw_valid;
    logic                        aw_ready;

    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic [AXI_USER_WIDTH-1:0]   w_user;
    logic                        w_valid;
    logic                        w_ready;

    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                  b_resp;
    logic [AXI_USER_WIDTH-1:0]   b_user;
    logic                        b_valid;
    logic                        b_ready;

    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic                        ar_lock;
    logic [3:0]                  ar_cache;
    logic [2:0]                  ar_prot;
    logic [3:0]                  ar_qos;
    logic [3:0]                  ar_region;
    logic [AXI_USER_WIDTH-1:0]   ar_user;
    logic                        ar_valid;
    logic                        ar_ready;

    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic [AXI_USER_WIDTH-1:0]   r_user;
    logic                        r_valid;
    logic                        r_ready;

    modport out (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );
endinterface

// File: rtl/axi_mem_master.sv
// Single-outstanding AXI4 initiator: converts a req/gnt memory port into
// single-beat AXI read/write transactions, one transaction in flight.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   req_i/gnt_o       client request / combinational grant (IDLE only)
//   we_i, addr_i,     write enable, byte address, byte enables, write data
//   be_i, wdata_i     (all registered on grant)
//   rvalid_o          one-cycle completion pulse for reads and writes
//   rdata_o           read data (holds last read, 0 after a write)
//   err_o             completion error, valid with rvalid_o
//   axi               AXI4 initiator port
module axi_mem_master
    import axi_mem_master_pkg::*;
#(
    parameter int unsigned AXI_ID_WIDTH   = 5,
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned AXI_ID         = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_i,
    output logic                        gnt_o,
    input  logic                        we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    output logic                        rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    AXI_BUS.out                         axi
);

    localparam logic [AXI_ID_WIDTH-1:0] ID_VAL   = AXI_ID_WIDTH'(AXI_ID);
    localparam logic [2:0]              SIZE_VAL = axi_size(AXI_DATA_WIDTH);

    state_e                      state_r;
    logic [AXI_ADDR_WIDTH-1:0]   addr_r;
    logic [AXI_DATA_WIDTH/8-1:0] be_r;
    logic [AXI_DATA_WIDTH-1:0]   wdata_r;
    logic                        aw_valid_r;
    logic                        w_valid_r;
    logic                        aw_done_r;
    logic                        w_done_r;
    logic                        ar_valid_r;
    logic                        b_ready_r;
    logic                        r_ready_r;
    logic                        rvalid_r;
    logic                        err_r;
    logic [AXI_DATA_WIDTH-1:0]   rdata_r;

    logic                        aw_done_s;
    logic                        w_done_s;
    logic                        b_err_s;
    logic                        r_err_s;

    // Grant is combinational so a request in IDLE is accepted without a stall.
    assign gnt_o = (state_r == IDLE) && req_i && !rst_i;

    // Handshake completion (including this cycle) and response error decode.
    always_comb begin
        aw_done_s = aw_done_r | (aw_valid_r & axi.aw_ready);
        w_done_s  = w_done_r  | (w_valid_r  & axi.w_ready);
        b_err_s   = (axi.b_resp != RESP_OKAY) || (axi.b_id != ID_VAL);
        r_err_s   = (axi.r_resp != RESP_OKAY) || !axi.r_last || (axi.r_id != ID_VAL);
    end

    // Transaction FSM with registered AXI handshake signals and client outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            addr_r     <= '0;
            be_r       <= '0;
            wdata_r    <= '0;
            aw_valid_r <= 1'b0;
            w_valid_r  <= 1'b0;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            ar_valid_r <= 1'b0;
            b_ready_r  <= 1'b0;
            r_ready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            err_r      <= 1'b0;
            rdata_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (gnt_o) begin
                        addr_r    <= addr_i;
                        be_r      <= be_i;
                        wdata_r   <= wdata_i;
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        if (we_i) begin
                            state_r    <= WRITE;
                            aw_valid_r <= 1'b1;
                            w_valid_r  <= 1'b1;
                        end else begin
                            state_r    <= READ;
                            ar_valid_r <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // AW and W complete independently; each valid drops after its own handshake.
                    aw_valid_r <= aw_valid_r & ~axi.aw_ready;
                    w_valid_r  <= w_valid_r  & ~axi.w_ready;
                    aw_done_r  <= aw_done_s;
                    w_done_r   <= w_done_s;
                    if (aw_done_s && w_done_s) begin
                        state_r   <= BWAIT;
                        b_ready_r <= 1'b1;
                    end
                end
                BWAIT: begin
                    if (axi.b_valid) begin
                        state_r   <= RESP;
                        b_ready_r <= 1'b0;
                        rvalid_r  <= 1'b1;
                        err_r     <= b_err_s;
                        rdata_r   <= '0;
                    end
                end
                READ: begin
                    if (axi.ar_ready) begin
                        state_r    <= RWAIT;
                        ar_valid_r <= 1'b0;
                        r_ready_r  <= 1'b1;
                    end
                end
                RWAIT: begin
                    if (axi.r_valid) begin
                        state_r   <= RESP;
                        r_ready_r <= 1'b0;
                        rvalid_r  <= 1'b1;
                        err_r     <= r_err_s;
                        rdata_r   <= axi.r_data;
                    end
                end
                RESP: begin
                    state_r  <= IDLE;
                    rvalid_r <= 1'b0;
                    err_r    <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: fall back to a quiet IDLE.
                    state_r    <= IDLE;
                    aw_valid_r <= 1'b0;
                    w_valid_r  <= 1'b0;
                    ar_valid_r <= 1'b0;
                    b_ready_r  <= 1'b0;
                    r_ready_r  <= 1'b0;
                    rvalid_r   <= 1'b0;
                    err_r      <= 1'b0;
                end
            endcase
        end
    end

    assign rvalid_o = rvalid_r;
    assign rdata_o  = rdata_r;
    assign err_o    = err_r;

    assign axi.aw_id     = ID_VAL;
    assign axi.aw_addr   = addr_r;
    assign axi.aw_len    = 8'd0;
    assign axi.aw_size   = SIZE_VAL;
    assign axi.aw_burst  = BURST_INCR;
    assign axi.aw_lock   = 1'b0;
    assign axi.aw_cache  = CACHE_MODIFIABLE;
    assign axi.aw_prot   = 3'd0;
    assign axi.aw_qos    = 4'd0;
    assign axi.aw_region = 4'd0;
    assign axi.aw_atop   = 6'd0;
    assign axi.aw_user   = {AXI_USER_WIDTH{1'b0}};
    assign axi.aw_valid  = aw_valid_r;

    assign axi.w_data    = wdata_r;
    assign axi.w_strb    = be_r;
    assign axi.w_last    = 1'b1;
    assign axi.w_user    = {AXI_USER_WIDTH{1'b0}};
    assign axi.w_valid   = w_valid_r;

    assign axi.b_ready   = b_ready_r;

    assign axi.ar_id     = ID_VAL;
    assign axi.ar_addr   = addr_r;
    assign axi.ar_len    = 8'd0;
    assign axi.ar_size   = SIZE_VAL;
    assign axi.ar_burst  = BURST_INCR;
    assign axi.ar_lock   = 1'b0;
    assign axi.ar_cache  = CACHE_MODIFIABLE;
    assign axi.ar_prot   = 3'd0;
    assign axi.ar_qos    = 4'd0;
    assign axi.ar_region = 4'd0;
    assign axi.ar_user   = {AXI_USER_WIDTH{1'b0}};
    assign axi.ar_valid  = ar_valid_r;

    assign axi.r_ready   = r_ready_r;

endmodule

// File: tb/tb_axi_mem_master.sv
// Testbench for axi_mem_master: a stalling AXI memory target, a
// transaction-level reference model and a per-cycle compare step.
module tb_axi_mem_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, req_i, gnt_o, we_i, rvalid_o, err_o;
    logic [63:0] addr_i, wdata_i, rdata_o;
    logic [7:0]  be_i;

    AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(5), .AXI_USER_WIDTH(1)) axi_if ();

    axi_mem_master #(.AXI_ID_WIDTH(5), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64),
                     .AXI_USER_WIDTH(1), .AXI_ID(0)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
        .addr_i(addr_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .axi(axi_if)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit checking = 1'b0;

    // client drive requests, applied at the next negedge
    logic        c_rst = 1'b1, c_req = 1'b0, c_we = 1'b0;
    logic [63:0] c_addr = 64'd0, c_wdata = 64'd0;
    logic [7:0]  c_be = 8'd0;

    // target knobs
    int ready_pct = 100, dly_min = 0, dly_max = 0, aw_hold = 0, w_hold = 0, force_err = 0;
    bit rnd_err = 1'b0;

    // target state
    logic [63:0] slv_mem [logic [63:0]];
    bit          s_have_aw, s_have_w, s_b_pend, s_b_valid, s_r_pend, s_r_valid;
    int          s_b_dly, s_r_dly;
    logic [63:0] s_aw_addr, s_w_data, s_r_data;
    logic [7:0]  s_w_strb;
    logic [1:0]  s_b_resp, s_r_resp;
    logic [4:0]  s_b_id, s_r_id;
    logic        s_r_last;

    // reference model: transaction phase 0 idle, 1 address, 2 response wait, 3 completion
    logic [63:0] sb_mem [logic [63:0]];
    bit          m_busy, m_we, m_aw_pend, m_w_pend, m_ar_pend, m_rv, m_err;
    int          m_phase;
    logic [63:0] m_addr, m_wdata, m_exp_rd, m_rdata;
    logic [7:0]  m_be;

    // observations for the directed checks
    bit          last_gnt, last_rv;
    int          obs_rv_cnt, obs_aw_cyc, obs_w_cyc, obs_b_cnt, obs_g_cyc, obs_rv_cyc;
    logic [63:0] obs_rdata;
    logic        obs_err, obs_wlast;
    logic [7:0]  obs_len;
    logic [2:0]  obs_size;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    function automatic bit roll(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    task automatic pick_resp(input bit is_read, output logic [1:0] resp, output logic [4:0] id, output logic last);
        int k;
        resp = 2'b00; id = 5'd0; last = 1'b1;
        k = (force_err != 0) ? force_err : (rnd_err ? int'($urandom_range(1, 12)) : 0);
        case (k)
            1: resp = 2'b10;
            2: id = 5'd1;
            3: last = !is_read;
            4: resp = 2'b11;
            default: ;
        endcase
    endtask

    // One clock cycle: drive at negedge, sample and compare, then advance target and model.
    task automatic step();
        bit exp_gnt, nxt_rv;
        logic [63:0] k;
        @(negedge clk);
        rst_i = c_rst; req_i = c_req; we_i = c_we; addr_i = c_addr; be_i = c_be; wdata_i = c_wdata;
        axi_if.aw_ready = (aw_hold > 0) ? 1'b0 : roll(ready_pct);
        axi_if.w_ready  = (w_hold > 0)  ? 1'b0 : roll(ready_pct);
        axi_if.ar_ready = roll(ready_pct);
        if (s_b_pend && !s_b_valid) begin
            if (s_b_dly == 0) s_b_valid = 1'b1; else s_b_dly--;
        end
        if (s_r_pend && !s_r_valid) begin
            if (s_r_dly == 0) s_r_valid = 1'b1; else s_r_dly--;
        end
        axi_if.b_valid = s_b_valid; axi_if.b_resp = s_b_resp; axi_if.b_id = s_b_id;
        axi_if.r_valid = s_r_valid; axi_if.r_resp = s_r_resp; axi_if.r_id = s_r_id;
        axi_if.r_last  = s_r_last;  axi_if.r_data = s_r_data;
        #1;
        cyc++;
        exp_gnt  = req_i && !m_busy && !rst_i;
        last_gnt = gnt_o;
        last_rv  = rvalid_o;
        if (checking) begin
            chk("gnt", 128'(gnt_o), 128'(exp_gnt));
            chk("aw_valid", 128'(axi_if.aw_valid), 128'(m_aw_pend));
            chk("w_valid", 128'(axi_if.w_valid), 128'(m_w_pend));
            chk("ar_valid", 128'(axi_if.ar_valid), 128'(m_ar_pend));
            chk("b_ready", 128'(axi_if.b_ready), 128'(m_phase == 2 && m_we));
            chk("r_ready", 128'(axi_if.r_ready), 128'(m_phase == 2 && !m_we));
            chk("rvalid", 128'(rvalid_o), 128'(m_rv));
            chk("err", 128'(err_o), 128'(m_rv && m_err));
            chk("rdata", 128'(rdata_o), 128'(m_rdata));
            if (m_aw_pend)
                chk("aw_payload", 128'({axi_if.aw_addr, axi_if.aw_id, axi_if.aw_len, axi_if.aw_size,
                    axi_if.aw_burst, axi_if.aw_lock, axi_if.aw_cache, axi_if.aw_prot, axi_if.aw_qos,
                    axi_if.aw_region, axi_if.aw_atop, axi_if.aw_user}),
                    128'({m_addr, 5'd0, 8'd0, 3'd3, 2'b01, 1'b0, 4'b0010, 3'd0, 4'd0, 4'd0, 6'd0, 1'b0}));
            if (m_w_pend)
                chk("w_payload", 128'({axi_if.w_data, axi_if.w_strb, axi_if.w_last, axi_if.w_user}),
                    128'({m_wdata, m_be, 1'b1, 1'b0}));
            if (m_ar_pend)
                chk("ar_payload", 128'({axi_if.ar_addr, axi_if.ar_id, axi_if.ar_len, axi_if.ar_size,
                    axi_if.ar_burst, axi_if.ar_lock, axi_if.ar_cache, axi_if.ar_prot, axi_if.ar_qos,
                    axi_if.ar_region, axi_if.ar_user}),
                    128'({m_addr, 5'd0, 8'd0, 3'd3, 2'b01, 1'b0, 4'b0010, 3'd0, 4'd0, 4'd0, 1'b0}));
        end
        if (gnt_o) obs_g_cyc = cyc;
        if (axi_if.aw_valid) begin obs_aw_cyc++; obs_len = axi_if.aw_len; obs_size = axi_if.aw_size; end
        if (axi_if.w_valid) begin obs_w_cyc++; obs_wlast = axi_if.w_last; end
        if (rvalid_o) begin obs_rv_cnt++; obs_rv_cyc = cyc; obs_rdata = rdata_o; obs_err = err_o; end

        if (rst_i) begin
            m_busy = 0; m_phase = 0; m_aw_pend = 0; m_w_pend = 0; m_ar_pend = 0;
            m_rv = 0; m_err = 0; m_rdata = 64'd0;
            s_have_aw = 0; s_have_w = 0; s_b_pend = 0; s_b_valid = 0; s_r_pend = 0; s_r_valid = 0;
        end else begin
            // model: advance the transaction using the readies/responses the target offered
            nxt_rv = 1'b0;
            if (m_rv) begin m_busy = 0; m_phase = 0; end
            if (m_phase == 1) begin
                if (m_aw_pend && axi_if.aw_ready) m_aw_pend = 0;
                if (m_w_pend && axi_if.w_ready) m_w_pend = 0;
                if (m_ar_pend && axi_if.ar_ready) m_ar_pend = 0;
                if (!m_aw_pend && !m_w_pend && !m_ar_pend) m_phase = 2;
            end else if (m_phase == 2) begin
                if (m_we && s_b_valid) begin
                    nxt_rv = 1; m_phase = 3; m_rdata = 64'd0;
                    m_err = (s_b_resp != 2'b00) || (s_b_id != 5'd0);
                end else if (!m_we && s_r_valid) begin
                    nxt_rv = 1; m_phase = 3; m_rdata = m_exp_rd;
                    m_err = (s_r_resp != 2'b00) || (s_r_id != 5'd0) || !s_r_last;
                end
            end
            m_rv = nxt_rv;
            if (exp_gnt) begin
                m_busy = 1; m_phase = 1; m_we = we_i; m_addr = addr_i; m_be = be_i; m_wdata = wdata_i;
                k = addr_i >> 3;
                if (we_i) begin
                    m_aw_pend = 1; m_w_pend = 1;
                    sb_mem[k] = merge(sb_mem.exists(k) ? sb_mem[k] : 64'd0, wdata_i, be_i);
                end else begin
                    m_ar_pend = 1;
                    m_exp_rd = sb_mem.exists(k) ? sb_mem[k] : 64'd0;
                end
            end
            // target: react to what the DUT actually presented
            if (axi_if.aw_valid && aw_hold > 0) aw_hold--;
            if (axi_if.w_valid && w_hold > 0) w_hold--;
            if (axi_if.aw_valid && axi_if.aw_ready) begin s_have_aw = 1; s_aw_addr = axi_if.aw_addr; end
            if (axi_if.w_valid && axi_if.w_ready) begin
                s_have_w = 1; s_w_data = axi_if.w_data; s_w_strb = axi_if.w_strb;
            end
            if (s_b_valid && axi_if.b_ready) begin s_b_pend = 0; s_b_valid = 0; obs_b_cnt++; end
            if (s_r_valid && axi_if.r_ready) begin s_r_pend = 0; s_r_valid = 0; end
            if (s_have_aw && s_have_w) begin
                k = s_aw_addr >> 3;
                slv_mem[k] = merge(slv_mem.exists(k) ? slv_mem[k] : 64'd0, s_w_data, s_w_strb);
                s_have_aw = 0; s_have_w = 0; s_b_pend = 1; s_b_valid = 0;
                s_b_dly = $urandom_range(dly_min, dly_max);
                pick_resp(1'b0, s_b_resp, s_b_id, s_r_last);
                s_r_last = 1'b1;
            end
            if (axi_if.ar_valid && axi_if.ar_ready) begin
                k = axi_if.ar_addr >> 3;
                s_r_data = slv_mem.exists(k) ? slv_mem[k] : 64'd0;
                s_r_pend = 1; s_r_valid = 0;
                s_r_dly = $urandom_range(dly_min, dly_max);
                pick_resp(1'b1, s_r_resp, s_r_id, s_r_last);
            end
        end
    endtask

    // Present one request, wait for its grant and its completion pulse.
    task automatic do_op(input logic we, input logic [63:0] addr, input logic [7:0] be, input logic [63:0] d);
        bit got;
        c_req = 1'b1; c_we = we; c_addr = addr; c_be = be; c_wdata = d;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin step(); got = last_gnt; end
        c_req = 1'b0;
        chk("grant_timeout", 128'(got), 128'(1));
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin step(); got = last_rv; end
        chk("completion_timeout", 128'(got), 128'(1));
    endtask

    initial begin
        int ops, guard, snap;
        bit seen;
        axi_if.b_user = 1'b0; axi_if.r_user = 1'b0;
        s_r_last = 1'b1; s_b_resp = 2'b00; s_r_resp = 2'b00; s_b_id = 5'd0; s_r_id = 5'd0;
        s_r_data = 64'd0;
        repeat (3) step();
        c_rst = 1'b0;
        checking = 1'b1;
        step();
        chk("reset_rdata", 128'(rdata_o), 128'(0));
        chk("reset_rvalid", 128'(rvalid_o), 128'(0));
        chk("reset_valids", 128'({axi_if.aw_valid, axi_if.w_valid, axi_if.ar_valid, axi_if.b_ready, axi_if.r_ready}), 128'(0));

        // zero-stall write then read
        do_op(1'b1, 64'h1000, 8'hFF, 64'hDEADBEEF_CAFEF00D);
        chk("wr_latency", 128'(obs_rv_cyc - obs_g_cyc), 128'(3));
        chk("wr_err", 128'(obs_err), 128'(0));
        chk("aw_len", 128'(obs_len), 128'(0));
        chk("aw_size", 128'(obs_size), 128'(3));
        chk("w_last", 128'(obs_wlast), 128'(1));
        do_op(1'b0, 64'h1000, 8'hFF, 64'd0);
        chk("rd_data", 128'(obs_rdata), 128'(64'hDEADBEEF_CAFEF00D));
        chk("rd_err", 128'(obs_err), 128'(0));
        chk("rd_latency", 128'(obs_rv_cyc - obs_g_cyc), 128'(3));

        // partial write over zero
        do_op(1'b1, 64'h2000, 8'h0F, 64'h11223344_55667788);
        do_op(1'b0, 64'h2000, 8'hFF, 64'd0);
        chk("partial_rd", 128'(obs_rdata), 128'(64'h00000000_55667788));

        // AW held off for 5 cycles, W accepted at once
        obs_aw_cyc = 0; obs_w_cyc = 0; obs_b_cnt = 0; aw_hold = 5;
        do_op(1'b1, 64'h1008, 8'hFF, 64'h0123_4567_89AB_CDEF);
        chk("awhold_aw_cycles", 128'(obs_aw_cyc), 128'(6));
        chk("awhold_w_cycles", 128'(obs_w_cyc), 128'(1));
        chk("awhold_b_count", 128'(obs_b_cnt), 128'(1));

        // W held off instead
        obs_aw_cyc = 0; obs_w_cyc = 0; obs_b_cnt = 0; w_hold = 5;
        do_op(1'b1, 64'h1010, 8'hFF, 64'hFEDC_BA98_7654_3210);
        chk("whold_aw_cycles", 128'(obs_aw_cyc), 128'(1));
        chk("whold_w_cycles", 128'(obs_w_cyc), 128'(6));
        chk("whold_b_count", 128'(obs_b_cnt), 128'(1));

        // error responses
        obs_rv_cnt = 0; force_err = 1;
        do_op(1'b0, 64'h1000, 8'hFF, 64'd0);
        chk("slverr_err", 128'(obs_err), 128'(1));
        chk("slverr_rdata", 128'(obs_rdata), 128'(64'hDEADBEEF_CAFEF00D));
        step();
        chk("slverr_one_pulse", 128'(obs_rv_cnt), 128'(1));
        force_err = 2;
        do_op(1'b1, 64'h1018, 8'hFF, 64'h5555_AAAA_5555_AAAA);
        chk("bid_err", 128'(obs_err), 128'(1));
        chk("rdata_after_write", 128'(rdata_o), 128'(0));
        force_err = 0;

        // randomized mixed traffic with stalls and occasional error responses
        ready_pct = 60; dly_min = 0; dly_max = 3; rnd_err = 1'b1;
        ops = 0; guard = 0;
        while (ops < 1000 && guard < 40000) begin
            c_req = roll(70); c_we = $urandom_range(0, 1);
            c_addr = 64'h3000 + 64'($urandom_range(0, 15) * 8);
            c_be = 8'($urandom); c_wdata = {$urandom, $urandom};
            step();
            if (last_gnt) ops++;
            guard++;
        end
        c_req = 1'b0;
        chk("random_ops", 128'(ops), 128'(1000));
        for (int i = 0; i < 200 && m_busy; i++) step();
        chk("random_drain", 128'(m_busy), 128'(0));
        rnd_err = 1'b0; ready_pct = 100; dly_max = 0;

        // reset while waiting for read data
        dly_min = 20; dly_max = 20;
        c_req = 1'b1; c_we = 1'b0; c_addr = 64'h1000;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin step(); seen = last_gnt; end
        c_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin step(); seen = axi_if.r_ready; end
        chk("rwait_reached", 128'(seen), 128'(1));
        snap = obs_rv_cnt;
        c_rst = 1'b1; step();
        c_rst = 1'b0; step();
        chk("rst_valids", 128'({axi_if.aw_valid, axi_if.w_valid, axi_if.ar_valid, axi_if.b_ready, axi_if.r_ready}), 128'(0));
        repeat (30) step();
        chk("rst_no_rvalid", 128'(obs_rv_cnt), 128'(snap));
        dly_min = 0; dly_max = 0;
        do_op(1'b0, 64'h1000, 8'hFF, 64'd0);
        chk("post_rst_rd", 128'(obs_rdata), 128'(64'hDEADBEEF_CAFEF00D));
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
